// File: rtl/csr_counter_unit_if.sv
// CSR access port and retirement/event inputs for csr_counter_unit.
interface csr_counter_unit_if #(
   parameter int NUM_HPM = 2
);
   localparam int HW = (NUM_HPM > 0) ? NUM_HPM : 1;

   logic          en;
   logic [11:0]   addr;
   logic [1:0]    funct;
   logic [31:0]   in_data;
   logic [31:0]   out_data;
   logic          illegal;
   logic          instret_inc;
   logic [HW-1:0] hpm_event;

   modport master (
      output en, addr, funct, in_data, instret_inc, hpm_event,
      input  out_data, illegal
   );

   modport slave (
      input  en, addr, funct, in_data, instret_inc, hpm_event,
      output out_data, illegal
   );
endinterface

// File: rtl/csr_counter_unit.sv
// 64-bit cycle/time/instret/hpm counters with machine-mode CSR read-modify-write
// and read-only user aliases; reads return the pre-edge value combinationally.
module csr_counter_unit #(
   parameter int NUM_HPM  = 2,
   parameter int TIME_DIV = 1
) (
   input logic               clk,
   input logic               reset,
   csr_counter_unit_if.slave bus
);
   localparam int HW = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam int PW = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
   localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

   logic [63:0]   cyc_q, cyc_d, tim_q, tim_d, ins_q, ins_d;
   logic [63:0]   hpm_q [HW];
   logic [63:0]   hpm_d [HW];
   logic [31:0]   inh_q, inh_d;
   logic [PW-1:0] presc_q, presc_d;

   logic          mapped, ro, hi, wr_intent, do_wr, tick;
   logic          tgt_cyc, tgt_ins, tgt_inh;
   logic [HW-1:0] tgt_hpm;
   logic [31:0]   old_val, new_val;

   function automatic logic [31:0] half_of(input logic [63:0] v, input logic h);
      return h ? v[63:32] : v[31:0];
   endfunction

   // A write to one half replaces the increment for that cycle (no carry either).
   function automatic logic [63:0] upd(input logic [63:0] cur, input logic inc,
                                       input logic wr, input logic h,
                                       input logic [31:0] nv);
      if (wr) return h ? {nv, cur[31:0]} : {cur[63:32], nv};
      return cur + 64'(inc);
   endfunction

   always_comb begin
      mapped  = 1'b0;
      ro      = 1'b0;
      old_val = '0;
      tgt_cyc = 1'b0;
      tgt_ins = 1'b0;
      tgt_inh = 1'b0;
      tgt_hpm = '0;
      hi      = bus.addr[7];
      if (bus.addr == 12'h320) begin
         mapped  = 1'b1;
         tgt_inh = 1'b1;
         old_val = inh_q;
      end else if ((bus.addr[11:8] == 4'hC || bus.addr[11:8] == 4'hB) &&
                   bus.addr[6:5] == 2'b00) begin
         ro = (bus.addr[11:8] == 4'hC);
         if (bus.addr[4:0] == 5'd0) begin
            mapped  = 1'b1;
            tgt_cyc = 1'b1;
            old_val = half_of(cyc_q, hi);
         end else if (bus.addr[4:0] == 5'd1 && ro) begin
            mapped  = 1'b1;
            old_val = half_of(tim_q, hi);
         end else if (bus.addr[4:0] == 5'd2) begin
            mapped  = 1'b1;
            tgt_ins = 1'b1;
            old_val = half_of(ins_q, hi);
         end
         for (int i = 0; i < NUM_HPM; i++) begin
            if (bus.addr[4:0] == 5'(i + 3)) begin
               mapped     = 1'b1;
               tgt_hpm[i] = 1'b1;
               old_val    = half_of(hpm_q[i], hi);
            end
         end
      end

      wr_intent    = (bus.funct == 2'b01) || (bus.funct[1] && bus.in_data != '0);
      bus.illegal  = bus.en && (!mapped || (wr_intent && ro));
      bus.out_data = (bus.en && !bus.illegal) ? old_val : '0;
      do_wr        = bus.en && !bus.illegal && wr_intent;

      case (bus.funct)
         2'b10:   new_val = old_val | bus.in_data;
         2'b11:   new_val = old_val & ~bus.in_data;
         default: new_val = bus.in_data;
      endcase
   end

   always_comb begin
      cyc_d = upd(cyc_q, !inh_q[0], do_wr && tgt_cyc, hi, new_val);
      ins_d = upd(ins_q, bus.instret_inc && !inh_q[2], do_wr && tgt_ins, hi, new_val);
      for (int i = 0; i < HW; i++) hpm_d[i] = hpm_q[i];
      for (int i = 0; i < NUM_HPM; i++)
         hpm_d[i] = upd(hpm_q[i], bus.hpm_event[i] && !inh_q[3+i],
                        do_wr && tgt_hpm[i], hi, new_val);
      // Mask changes only affect increments from the next edge on.
      inh_d   = (do_wr && tgt_inh) ? (new_val & INH_MASK) : inh_q;
      tick    = (presc_q == PW'(TIME_DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      tim_d   = tim_q + 64'(tick);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q   <= '0;
         tim_q   <= '0;
         ins_q   <= '0;
         inh_q   <= '0;
         presc_q <= '0;
         for (int i = 0; i < HW; i++) hpm_q[i] <= '0;
      end else begin
         cyc_q   <= cyc_d;
         tim_q   <= tim_d;
         ins_q   <= ins_d;
         inh_q   <= inh_d;
         presc_q <= presc_d;
         hpm_q   <= hpm_d;
      end
   end
endmodule

// File: tb/tb_csr_counter_unit.sv
// Bench for csr_counter_unit: directed test-plan sequences, a decode table, and
// randomized CSR traffic checked against a counter-level reference model.
module tb_csr_counter_unit;
   localparam int NH = 2;
   localparam int TD = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   csr_counter_unit_if #(.NUM_HPM(NH)) bus ();
   csr_counter_unit #(.NUM_HPM(NH), .TIME_DIV(TD)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // Model: index 0 cycle, 2 instret, 3.. hpm; time derived from edges since reset.
   longint unsigned m_cnt [0:4];
   logic [31:0]     m_inh;
   int              m_cyc;

   typedef struct {
      logic        e;
      logic [11:0] a;
      logic [1:0]  f;
      logic [31:0] d;
      logic        x_ill;
   } vec_t;
   vec_t tbl[$];

   logic [11:0] pool [20] = '{12'hC00, 12'hC80, 12'hC01, 12'hC81, 12'hC02, 12'hC82,
                              12'hC03, 12'hC84, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                              12'hB03, 12'hB83, 12'hB04, 12'hB84, 12'h320, 12'hB05,
                              12'hB01, 12'hC85};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void mdl_clear();
      for (int k = 0; k < 5; k++) m_cnt[k] = 0;
      m_inh = 0;
      m_cyc = 0;
   endfunction

   function automatic void mdl_eval(input logic e, input logic [11:0] a, input logic [1:0] f,
                                    input logic [31:0] d, output logic ill,
                                    output logic [31:0] rd, output logic wr, output int id,
                                    output logic hi, output logic inhsel);
      int grp, idx;
      logic intent;
      longint unsigned v;
      ill = 0; rd = 0; wr = 0; id = -1; hi = a[7]; inhsel = 0;
      intent = (f == 2'b01) || (f[1] && d != 0);
      if (!e) return;
      grp = int'(a) / 256;
      idx = int'(a) % 128;
      if (a == 12'h320) begin
         inhsel = 1;
         rd = m_inh;
      end else if ((grp == 12 || grp == 11) && idx < 3 + NH && !(grp == 11 && idx == 1)) begin
         id = idx;
         v = (idx == 1) ? 64'(m_cyc / TD) : m_cnt[idx];
         rd = hi ? v[63:32] : v[31:0];
         if (grp == 12 && intent) ill = 1;
      end else begin
         ill = 1;
      end
      if (ill) begin rd = 0; id = -1; inhsel = 0; end
      wr = !ill && intent;
   endfunction

   function automatic void mdl_step(input logic e, input logic [11:0] a, input logic [1:0] f,
                                    input logic [31:0] d, input logic ii, input logic [1:0] ev);
      logic ill, wr, hi, inhsel;
      logic [31:0] rd, nv;
      int id;
      longint unsigned inc;
      mdl_eval(e, a, f, d, ill, rd, wr, id, hi, inhsel);
      nv = (f == 2'b01) ? d : (f == 2'b10) ? (rd | d) : (rd & ~d);
      for (int k = 0; k < 3 + NH; k++) begin
         if (k == 1) continue;
         if (k == 0) inc = 1;
         else if (k == 2) inc = 64'(ii);
         else inc = 64'(ev[k-3]);
         if (wr && id == k) m_cnt[k] = hi ? {nv, m_cnt[k][31:0]} : {m_cnt[k][63:32], nv};
         else if (!m_inh[k]) m_cnt[k] += inc;
      end
      if (wr && inhsel) m_inh = nv & 32'h1D;
      m_cyc++;
   endfunction

   // Called just after a rising edge; samples mid-cycle and returns after the next edge.
   task automatic op(input logic e, input logic [11:0] a, input logic [1:0] f,
                     input logic [31:0] d, input logic ii, input logic [1:0] ev,
                     output logic [31:0] o, output logic il);
      logic x_ill, x_wr, x_hi, x_inh;
      logic [31:0] x_rd;
      int x_id;
      bus.en = e; bus.addr = a; bus.funct = f; bus.in_data = d;
      bus.instret_inc = ii; bus.hpm_event = ev;
      #4;
      o  = bus.out_data;
      il = bus.illegal;
      mdl_eval(e, a, f, d, x_ill, x_rd, x_wr, x_id, x_hi, x_inh);
      chk($sformatf("illegal addr=%h funct=%0d", a, f), {31'b0, il}, {31'b0, x_ill});
      chk($sformatf("out_data addr=%h funct=%0d", a, f), o, x_rd);
      mdl_step(e, a, f, d, ii, ev);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic ii, input logic [1:0] ev);
      logic [31:0] o;
      logic il;
      for (int k = 0; k < n; k++) op(1'b0, 12'h000, 2'b00, 32'h0, ii, ev, o, il);
   endtask

   task automatic do_reset();
      bus.en = 0; bus.instret_inc = 0; bus.hpm_event = 0;
      reset = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 0;
      mdl_clear();
   endtask

   initial begin
      logic [31:0] o;
      logic il;
      bus.en = 0; bus.addr = 0; bus.funct = 0; bus.in_data = 0;
      bus.instret_inc = 0; bus.hpm_event = 0;
      mdl_clear();

      // Reset state and free-running cycle count.
      do_reset();
      op(1, 12'hC00, 2'b00, 0, 0, 0, o, il); chk("reset cycle", o, 32'h0);
      idle(9, 0, 0);
      op(1, 12'hC00, 2'b00, 0, 0, 0, o, il); chk("cycle after 10", o, 32'd10);
      op(1, 12'hC80, 2'b00, 0, 0, 0, o, il); chk("cycleh after 10", o, 32'h0);
      op(1, 12'h320, 2'b00, 0, 0, 0, o, il); chk("reset inhibit", o, 32'h0);

      // Low-half write then carry into the high half.
      op(1, 12'hB00, 2'b01, 32'hFFFF_FFFE, 0, 0, o, il);
      op(1, 12'hC00, 2'b00, 0, 0, 0, o, il); chk("mcycle written", o, 32'hFFFF_FFFE);
      op(1, 12'hC00, 2'b00, 0, 0, 0, o, il); chk("mcycle +1", o, 32'hFFFF_FFFF);
      op(1, 12'hC00, 2'b00, 0, 0, 0, o, il); chk("mcycle wrap low", o, 32'h0);
      op(1, 12'hC80, 2'b00, 0, 0, 0, o, il); chk("mcycle carry high", o, 32'h1);

      // Inhibit cycle and instret, then release.
      op(1, 12'h320, 2'b10, 32'h5, 1, 0, o, il);
      for (int k = 0; k < 4; k++) op(1, (k % 2) ? 12'hC02 : 12'hC00, 2'b00, 0, 1, 0, o, il);
      op(1, 12'h320, 2'b00, 0, 1, 0, o, il); chk("inhibit set", o, 32'h5);
      op(1, 12'h320, 2'b11, 32'h5, 1, 0, o, il);
      op(1, 12'hC00, 2'b00, 0, 1, 0, o, il);
      op(1, 12'hC02, 2'b00, 0, 1, 0, o, il);

      // Writes to user aliases.
      op(1, 12'hC02, 2'b01, 32'h1234, 1, 0, o, il);
      chk("ro write illegal", {31'b0, il}, 32'h1); chk("ro write out", o, 32'h0);
      op(1, 12'hC02, 2'b10, 32'h0, 0, 0, o, il);
      chk("ro rs zero legal", {31'b0, il}, 32'h0);

      // HPM decode range and event counting.
      do_reset();
      op(1, 12'hB05, 2'b00, 0, 0, 0, o, il); chk("hpm oob illegal", {31'b0, il}, 32'h1);
      idle(3, 0, 2'b10);
      op(1, 12'hB04, 2'b00, 0, 0, 0, o, il); chk("hpm1 count", o, 32'd3);
      op(1, 12'hB03, 2'b00, 0, 0, 0, o, il); chk("hpm0 count", o, 32'd0);

      // Time prescaler.
      do_reset();
      idle(9, 0, 0);
      op(1, 12'hC01, 2'b00, 0, 0, 0, o, il); chk("time after 9", o, 32'd2);
      op(1, 12'hB01, 2'b01, 32'h7, 0, 0, o, il); chk("mtime illegal", {31'b0, il}, 32'h1);

      // Decode table.
      tbl.push_back('{1'b1, 12'hC00, 2'b00, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 12'hC81, 2'b00, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 12'hC04, 2'b00, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 12'hC05, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 12'hC85, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 12'hB81, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 12'hC00, 2'b11, 32'h5, 1'b1});
      tbl.push_back('{1'b1, 12'hC80, 2'b11, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 12'hB02, 2'b01, 32'h55, 1'b0});
      tbl.push_back('{1'b1, 12'hB82, 2'b10, 32'h3, 1'b0});
      tbl.push_back('{1'b1, 12'h321, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 12'hC20, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 12'h000, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b1, 12'hFFF, 2'b00, 32'h0, 1'b1});
      tbl.push_back('{1'b0, 12'hFFF, 2'b01, 32'h1, 1'b0});
      tbl.push_back('{1'b0, 12'hC02, 2'b00, 32'h0, 1'b0});
      tbl.push_back('{1'b1, 12'hB02, 2'b00, 32'h0, 1'b0});
      for (int k = 0; k < tbl.size(); k++) begin
         op(tbl[k].e, tbl[k].a, tbl[k].f, tbl[k].d, 1'b1, 2'b01, o, il);
         chk($sformatf("table %0d illegal", k), {31'b0, il}, {31'b0, tbl[k].x_ill});
         if (!tbl[k].e) chk($sformatf("table %0d idle out", k), o, 32'h0);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] d;
         int r;
         r = $urandom_range(0, 3);
         if (r == 0) d = 0;
         else if (r == 1) d = $urandom;
         else if (r == 2) d = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
         else d = 32'($urandom_range(0, 31));
         op($urandom_range(0, 7) != 0, pool[$urandom_range(0, 19)], 2'($urandom_range(0, 3)),
            d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), o, il);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
